// File: rtl/sha256_pkg.sv
// sha256_pkg: shared SHA-256 schedule constants, K ROM, state encoding and sigma functions.
package sha256_pkg;
    localparam int WORD_W   = 32;
    localparam int N_ROUNDS = 64;

    localparam logic [31:0] K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    typedef enum logic [1:0] {IDLE, LOAD, EXPAND, DRAIN} state_e;

    function automatic logic [WORD_W-1:0] rotr(input logic [WORD_W-1:0] x, input int n);
        return (x >> n) | (x << (WORD_W - n));
    endfunction

    function automatic logic [WORD_W-1:0] sigma0(input logic [WORD_W-1:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [WORD_W-1:0] sigma1(input logic [WORD_W-1:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction
endpackage

// File: rtl/sha256_msg_schedule_if.sv
// sha256_msg_schedule_if: message-word input and schedule-word output handshakes of the schedule stage.
interface sha256_msg_schedule_if;
    import sha256_pkg::*;
    logic              start;
    logic              in_valid;
    logic              in_ready;
    logic [WORD_W-1:0] data_i;
    logic              w_valid;
    logic              w_ready;
    logic [WORD_W-1:0] w_o;
    logic [5:0]        t_o;
    logic [WORD_W-1:0] wk_o;
    logic              busy;
    logic              done;

    modport master (
        output start, in_valid, data_i, w_ready,
        input  in_ready, w_valid, w_o, t_o, wk_o, busy, done
    );
    modport slave (
        input  start, in_valid, data_i, w_ready,
        output in_ready, w_valid, w_o, t_o, wk_o, busy, done
    );
endinterface

// File: rtl/sha256_msg_sigma.sv
// sha256_msg_sigma: combinational expansion adder W_t = s1(W_t-2) + W_t-7 + s0(W_t-15) + W_t-16.
module sha256_msg_sigma
    import sha256_pkg::*;
(
    input  logic [WORD_W-1:0] w2,
    input  logic [WORD_W-1:0] w7,
    input  logic [WORD_W-1:0] w15,
    input  logic [WORD_W-1:0] w16,
    output logic [WORD_W-1:0] w
);
    assign w = sigma1(w2) + w7 + sigma0(w15) + w16;
endmodule

// File: rtl/sha256_msg_schedule.sv
// sha256_msg_schedule: SHA-256 message schedule, 16 words in, W_0..W_63 out over a sliding window.
// Define SHA_SCHED_WK_EN to register W_t + K_t on wk_o; otherwise wk_o is tied to 0.
module sha256_msg_schedule
    import sha256_pkg::*;
(
    input logic CLK,
    input logic RST,
    sha256_msg_schedule_if.slave bus
);
    state_e            state;
    logic [5:0]        cnt;
    logic [WORD_W-1:0] win [16];
    logic [WORD_W-1:0] xw, dw, w_r;
    logic [5:0]        t_r;
    logic              wv, done_r, adv, acc, gen, load;

    assign adv  = !wv || bus.w_ready;
    assign acc  = state == LOAD && adv && bus.in_valid;
    assign gen  = state == EXPAND && adv;
    assign load = acc || gen;
    assign dw   = gen ? xw : bus.data_i;

    sha256_msg_sigma u_sigma (.w2(win[14]), .w7(win[9]), .w15(win[1]), .w16(win[0]), .w(xw));

    assign bus.in_ready = state == LOAD && adv;
    assign bus.w_valid  = wv;
    assign bus.w_o      = w_r;
    assign bus.t_o      = t_r;
    assign bus.busy     = state != IDLE;
    assign bus.done     = done_r;

`ifdef SHA_SCHED_WK_EN
    logic [WORD_W-1:0] wk_r;
    assign bus.wk_o = wk_r;
    always_ff @(posedge CLK or negedge RST)
        if (!RST) wk_r <= '0;
        else if (load) wk_r <= dw + K[cnt];
`else
    assign bus.wk_o = '0;
`endif

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state  <= IDLE;
            cnt    <= '0;
            w_r    <= '0;
            t_r    <= '0;
            wv     <= 1'b0;
            done_r <= 1'b0;
            for (int i = 0; i < 16; i++) win[i] <= '0;
        end else begin
            done_r <= state == DRAIN && wv && bus.w_ready;
            wv     <= load || (wv && !bus.w_ready);
            if (load) begin
                w_r <= dw;
                t_r <= cnt;
                cnt <= cnt + 6'd1;
                for (int i = 0; i < 15; i++) win[i] <= win[i+1];
                win[15] <= dw;
            end
            // the done cycle is already IDLE, so a start there must be masked
            case (state)
                IDLE:    if (bus.start && !done_r) begin state <= LOAD; cnt <= '0; end
                LOAD:    if (acc && cnt == 6'd15) state <= EXPAND;
                EXPAND:  if (gen && cnt == 6'(N_ROUNDS - 1)) state <= DRAIN;
                DRAIN:   if (wv && bus.w_ready) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sha256_msg_schedule.sv
// tb_sha256_msg_schedule: randomized directed bench checking the schedule against a whole-block reference model.
module tb_sha256_msg_schedule;
    typedef logic [31:0] blk_t [16];
    typedef logic [31:0] sch_t [64];

    logic CLK = 1'b0;
    logic RST;
    int checks = 0;
    int errors = 0;

    sha256_msg_schedule_if bus ();
    sha256_msg_schedule dut (.CLK(CLK), .RST(RST), .bus(bus));

    always #5 CLK = ~CLK;

`ifdef SHA_SCHED_WK_EN
    localparam logic [31:0] KT [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };
`endif

    function automatic logic [31:0] ror(input logic [31:0] x, input int n);
        logic [63:0] d;
        d = {x, x} >> n;
        return d[31:0];
    endfunction

    function automatic void sched(input blk_t m, output sch_t w);
        for (int t = 0; t < 64; t++)
            w[t] = t < 16 ? m[t] :
                (ror(w[t-2], 17) ^ ror(w[t-2], 19) ^ (w[t-2] >> 10)) + w[t-7] +
                (ror(w[t-15], 7) ^ ror(w[t-15], 18) ^ (w[t-15] >> 3)) + w[t-16];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_w_o"}, bus.w_o, 0);
        chk({tag, "_t_o"}, 32'(bus.t_o), 0);
        chk({tag, "_wk_o"}, bus.wk_o, 0);
        chk({tag, "_w_valid"}, 32'(bus.w_valid), 0);
        chk({tag, "_in_ready"}, 32'(bus.in_ready), 0);
        chk({tag, "_busy"}, 32'(bus.busy), 0);
        chk({tag, "_done"}, 32'(bus.done), 0);
    endtask

    // stall: percent of cycles with w_ready low (0 = no stalls, no input gaps)
    task automatic run_block(input blk_t m, input int stall, input bit poke, input int abort_at, output sch_t got);
        sch_t exp;
        int n, sent, dones;
        bit held, aborted;
        logic [31:0] hw, hk;
        logic [5:0] ht;
        sched(m, exp);
        n = 0; sent = 0; dones = 0; held = 0; aborted = 0;
        got = '{default: '0};
        @(posedge CLK); #1; bus.start = 1'b1;
        @(posedge CLK); #1; bus.start = 1'b0;
        chk("busy_after_start", 32'(bus.busy), 1);
        for (int cyc = 0; cyc < 4000; cyc++) begin
            if (cyc > 0) begin @(posedge CLK); #1; end
            if (held) begin
                chk("hold_w_o", bus.w_o, hw);
                chk("hold_t_o", 32'(bus.t_o), 32'(ht));
                chk("hold_wk_o", bus.wk_o, hk);
            end
            if (dones > 0 && !bus.done) break;
            if (bus.done) dones++;
            bus.w_ready  = stall == 0 ? 1'b1 : ($urandom_range(99) >= stall);
            bus.in_valid = stall == 0 ? 1'b1 : 1'($urandom_range(1));
            bus.data_i   = sent < 16 ? m[sent] : $urandom;
            bus.start    = poke ? 1'($urandom_range(1)) : 1'b0;
            #1;
            if (sent == 16) chk("in_ready_expand", 32'(bus.in_ready), 0);
            if (bus.in_valid && bus.in_ready) sent++;
            if (bus.w_valid && bus.w_ready && n < 64) begin
                got[n] = bus.w_o;
                chk($sformatf("w_%0d", n), bus.w_o, exp[n]);
                chk($sformatf("t_%0d", n), 32'(bus.t_o), n);
`ifdef SHA_SCHED_WK_EN
                chk($sformatf("wk_%0d", n), bus.wk_o, exp[n] + KT[n]);
`else
                chk($sformatf("wk_%0d", n), bus.wk_o, 0);
`endif
                n++;
                if (n == abort_at + 1) begin
                    RST = 1'b0;
                    #1;
                    check_zero("abort");
                    aborted = 1;
                    break;
                end
            end
            held = bus.w_valid && !bus.w_ready;
            hw = bus.w_o; ht = bus.t_o; hk = bus.wk_o;
        end
        bus.start = 1'b0; bus.in_valid = 1'b0; bus.w_ready = 1'b0;
        if (aborted) begin
            repeat (3) begin
                @(posedge CLK); #1;
                check_zero("in_reset");
            end
            RST = 1'b1;
            @(posedge CLK); #1;
            chk("no_done_abort", 32'(bus.done), 0);
            chk("idle_after_abort", 32'(bus.busy), 0);
        end else begin
            chk("word_count", n, 64);
            chk("done_once", dones, 1);
            @(posedge CLK); #1;
            chk("idle_after_done", 32'(bus.busy), 0);
            chk("no_second_done", 32'(bus.done), 0);
        end
    endtask

    function automatic blk_t rand_blk();
        blk_t b;
        foreach (b[i]) b[i] = $urandom;
        return b;
    endfunction

    initial begin
        blk_t abc;
        sch_t got;
        RST = 1'b0;
        bus.start = 1'b0; bus.in_valid = 1'b0; bus.w_ready = 1'b0; bus.data_i = '0;
        repeat (2) @(posedge CLK);
        #1;
        check_zero("reset");
        RST = 1'b1;
        bus.in_valid = 1'b1; bus.data_i = 32'hdeadbeef; bus.w_ready = 1'b1;
        repeat (3) begin
            @(posedge CLK); #1;
            chk("in_ready_idle", 32'(bus.in_ready), 0);
            chk("w_valid_idle", 32'(bus.w_valid), 0);
            chk("busy_idle", 32'(bus.busy), 0);
        end
        bus.in_valid = 1'b0;

        abc = '{default: '0};
        abc[0] = 32'h61626380;
        abc[15] = 32'h00000018;
        run_block(abc, 0, 1'b0, -1, got);
        chk("abc_w16", got[16], 32'h61626380);
        chk("abc_w17", got[17], 32'h000f0000);
        chk("abc_w63", got[63], 32'h12b1edeb);

        run_block(abc, 50, 1'b1, -1, got);
        run_block(rand_blk(), 50, 1'b1, -1, got);
        run_block(rand_blk(), 30, 1'b1, -1, got);
        run_block(rand_blk(), 40, 1'b0, 30, got);
        run_block(rand_blk(), 50, 1'b1, -1, got);
        run_block(abc, 0, 1'b0, -1, got);
        chk("abc2_w63", got[63], 32'h12b1edeb);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
